// File: rtl/reg_file_wb_arbiter.sv
// Write-back arbiter for the single reg_file write port: round-robin ALU/load grant,
// registered write port, and a per-register pending-write scoreboard for RAW hazard checks.
module reg_file_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [ADDR_WIDTH:0]   pending_cnt,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_reg,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic {GNT_ALU = 1'b0, GNT_MEM = 1'b1} grant_e;

  grant_e                last_grant_q, last_grant_d;
  logic                  alu_gnt, mem_gnt, xfer;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [CW-1:0]         pending_cnt_q, pending_cnt_d;
  logic                  sb_set, sb_clr, cnt_inc, cnt_dec;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_gnt      = alu_valid && (!mem_valid || (last_grant_q == GNT_MEM));
    mem_gnt      = mem_valid && !alu_gnt;
    xfer         = alu_gnt || mem_gnt;
    sel_rd       = alu_gnt ? alu_rd   : mem_rd;
    sel_data     = alu_gnt ? alu_data : mem_data;

    last_grant_d = last_grant_q;
    if (alu_gnt)      last_grant_d = GNT_ALU;
    else if (mem_gnt) last_grant_d = GNT_MEM;

    // Writes to x0 complete the handshake but never reach the register file.
    wr_en_d   = xfer && (sel_rd != '0);
    wr_reg_d  = xfer ? sel_rd   : wr_reg_q;
    wr_data_d = xfer ? sel_data : wr_data_q;
  end

  always_comb begin
    sb_set = issue_valid && (issue_rd != '0);
    sb_clr = wr_en_q;

    // Clear first, then set: a new reservation survives the commit of the old producer.
    busy_d = busy_q;
    if (sb_clr) busy_d[wr_reg_q] = 1'b0;
    if (sb_set) busy_d[issue_rd] = 1'b1;

    cnt_inc = sb_set && !busy_q[issue_rd];
    cnt_dec = sb_clr && busy_q[wr_reg_q] && !(sb_set && (issue_rd == wr_reg_q));
    pending_cnt_d = pending_cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q  <= GNT_MEM;
      wr_en_q       <= 1'b0;
      wr_reg_q      <= '0;
      wr_data_q     <= '0;
      // NOTE: the busy vector is reset, not left to power-up, because reset must drop all reservations.
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      wr_en_q       <= wr_en_d;
      wr_reg_q      <= wr_reg_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  assign alu_ready   = alu_gnt;
  assign mem_ready   = mem_gnt;
  assign wr_en       = wr_en_q;
  assign wr_reg      = wr_reg_q;
  assign wr_data     = wr_data_q;
  assign pending_cnt = pending_cnt_q;
  assign rs1_busy    = busy_q[rs1];
  assign rs2_busy    = busy_q[rs2];

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Bench for reg_file_wb_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_reg_file_wb_arbiter;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
  logic [AW-1:0] alu_rd = '0, mem_rd = '0, issue_rd = '0, rs1 = '0, rs2 = '0;
  logic [DW-1:0] alu_data = '0, mem_data = '0;
  logic          alu_ready, mem_ready, rs1_busy, rs2_busy, wr_en;
  logic [AW:0]   pending_cnt;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;

  int n_cmp = 0;
  int n_err = 0;

  reg_file_wb_arbiter #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .pending_cnt(pending_cnt),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Stand-in for reg_file: commits whatever the port presents.
  logic [DW-1:0] tb_rf [NR] = '{default: '0};
  always @(posedge clk) if (wr_en) tb_rf[wr_reg] <= wr_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit            m_last_was_alu = 1'b0;   // after reset the load unit counts as last served
  bit            m_busy [NR];
  bit            m_port_en = 1'b0;
  bit [AW-1:0]   m_port_reg = '0;
  bit [DW-1:0]   m_port_data = '0;
  bit [DW-1:0]   m_rf [NR];
  bit            m_alu_took = 1'b0, m_mem_took = 1'b0;

  // 0 = nobody, 1 = ALU, 2 = load unit
  function automatic int winner();
    if (alu_valid && mem_valid) return m_last_was_alu ? 2 : 1;
    if (alu_valid) return 1;
    if (mem_valid) return 2;
    return 0;
  endfunction

  function automatic int busy_count();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last_was_alu = 1'b0;
      m_port_en      = 1'b0;
      m_alu_took     = 1'b0;
      m_mem_took     = 1'b0;
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    end else begin
      automatic int w = winner();
      if (m_port_en) begin
        m_rf[m_port_reg]   = m_port_data;
        m_busy[m_port_reg] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      m_alu_took = (w == 1);
      m_mem_took = (w == 2);
      if (w == 0) begin
        m_port_en = 1'b0;
      end else begin
        m_port_reg     = (w == 1) ? alu_rd   : mem_rd;
        m_port_data    = (w == 1) ? alu_data : mem_data;
        m_port_en      = (m_port_reg != 0);
        m_last_was_alu = (w == 1);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      automatic int w = winner();
      check("alu_ready", alu_ready, w == 1);
      check("mem_ready", mem_ready, w == 2);
      check("wr_en", wr_en, m_port_en);
      if (m_port_en) begin
        check("wr_reg", wr_reg, m_port_reg);
        check("wr_data", wr_data, m_port_data);
      end
      check("rs1_busy", rs1_busy, (rs1 != 0) && m_busy[rs1]);
      check("rs2_busy", rs2_busy, (rs2 != 0) && m_busy[rs2]);
      check("pending_cnt", pending_cnt, busy_count());
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] a_rd [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
    logic [AW-1:0] m_rd [4] = '{5'd11, 5'd12, 5'd13, 5'd14};
    logic [AW-1:0] exp_seq [4] = '{5'd1, 5'd11, 5'd2, 5'd12};
    int ai, mi;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state, then reserve x5
    rs1 = 5'd5;
    mid();
    check("t1 wr_en", wr_en, 0);
    check("t1 pending", pending_cnt, 0);
    check("t1 rs1_busy", rs1_busy, 0);
    check("t1 rs2_busy", rs2_busy, 0);
    tick();
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    mid();
    check("t1 rs1_busy x5", rs1_busy, 1);
    check("t1 pending 1", pending_cnt, 1);

    // 2: ALU writes x5
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    mid();
    check("t2 alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    mid();
    check("t2 wr_en", wr_en, 1);
    check("t2 wr_reg", wr_reg, 5);
    check("t2 wr_data", wr_data, 32'hDEADBEEF);
    check("t2 rs1_busy on port", rs1_busy, 1);
    tick();
    mid();
    check("t2 rs1_busy after", rs1_busy, 0);
    check("t2 pending", pending_cnt, 0);
    check("t2 rf x5", tb_rf[5], 32'hDEADBEEF);

    // 3: load-only write first so the ALU wins the upcoming tie, then both valid
    tick();
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h20;
    tick();
    ai = 0; mi = 0;
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1; alu_rd = a_rd[ai]; alu_data = 32'hA0 + 32'(ai);
      mem_valid = 1'b1; mem_rd = m_rd[mi]; mem_data = 32'hB0 + 32'(mi);
      mid();
      check("t3 alu_ready", alu_ready, (k % 2) == 0);
      check("t3 mem_ready", mem_ready, (k % 2) == 1);
      if (k > 0) begin
        check("t3 wr_en", wr_en, 1);
        check("t3 wr_reg", wr_reg, exp_seq[k-1]);
      end
      tick();
      if ((k % 2) == 0) ai++; else mi++;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    mid();
    check("t3 wr_en last", wr_en, 1);
    check("t3 wr_reg last", wr_reg, 12);

    // 4: write to x0 and reservation of x0
    tick();
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFFFFFF;
    mid();
    check("t4 mem_ready", mem_ready, 1);
    tick();
    mem_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd0;
    mid();
    check("t4 wr_en", wr_en, 0);
    tick();
    issue_valid = 1'b0;
    mid();
    check("t4 rf x0", tb_rf[0], 0);
    check("t4 pending", pending_cnt, 0);

    // 5: re-reserve x7 while its write is on the port
    tick();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    mid();
    check("t5 alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    mid();
    check("t5 wr_en", wr_en, 1);
    check("t5 wr_reg", wr_reg, 7);
    check("t5 pending before", pending_cnt, 1);
    tick();
    issue_valid = 1'b0; rs1 = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
    mid();
    check("t5 rs1_busy x7", rs1_busy, 1);
    check("t5 pending after", pending_cnt, 1);
    tick();
    alu_valid = 1'b0;
    tick();
    mid();
    check("t5 pending cleared", pending_cnt, 0);

    // 6: asynchronous reset with a write to x9 on the port and three reservations
    tick();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_rd = 5'd3;
    tick();
    issue_rd = 5'd4;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    mid();
    check("t6 alu_ready", alu_ready, 1);
    tick();
    issue_valid = 1'b0; alu_valid = 1'b0; rs1 = 5'd9;
    mid();
    check("t6 wr_en before", wr_en, 1);
    check("t6 wr_reg before", wr_reg, 9);
    check("t6 pending before", pending_cnt, 3);
    #2 rst = 1'b1;
    #1;
    check("t6 wr_en async", wr_en, 0);
    check("t6 pending async", pending_cnt, 0);
    check("t6 rs1_busy async", rs1_busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mid();
    check("t6 rf x9", tb_rf[9], 0);

    // Randomized traffic; requesters hold until granted
    tick();
    for (int i = 0; i < 3000; i++) begin
      if (!(alu_valid && !m_alu_took)) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = AW'($urandom_range(0, 9));
        alu_data  = DW'($urandom);
      end
      if (!(mem_valid && !m_mem_took)) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd    = AW'($urandom_range(0, 9));
        mem_data  = DW'($urandom);
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = AW'($urandom_range(0, 9));
      rs1         = AW'($urandom_range(0, 10));
      rs2         = AW'($urandom_range(0, 31));
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    repeat (2) tick();
    mid();
    for (int r = 0; r < NR; r++) check($sformatf("rf x%0d", r), tb_rf[r], m_rf[r]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_wb_arbiter.md
Name: reg_file_wb_arbiter

Overview:
Sits between the core's two write-back sources (ALU and load unit) and the single write port of reg_file. It arbitrates the port round-robin using valid/ready handshakes and registers the winning write onto wr_en/wr_reg/wr_data. It also keeps a per-register pending-write scoreboard, so the issue stage can detect RAW hazards on rs1/rs2.

Parameters:
DATA_WIDTH, 32, width of write data
NUM_REGS, 32, number of architectural registers
ADDR_WIDTH, 5, register index width, equal to log2(NUM_REGS)

Ports:
clk  in  1  core clock, all state updates on posedge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU write-back request
alu_ready  out  1  ALU request accepted this cycle
alu_rd  in  ADDR_WIDTH  ALU destination register
alu_data  in  DATA_WIDTH  ALU result
mem_valid  in  1  load-unit write-back request
mem_ready  out  1  load request accepted this cycle
mem_rd  in  ADDR_WIDTH  load destination register
mem_data  in  DATA_WIDTH  load result
issue_valid  in  1  issue stage reserves a destination
issue_rd  in  ADDR_WIDTH  register being reserved
rs1, rs2  in  ADDR_WIDTH each  source registers to check
rs1_busy, rs2_busy  out  1 each  source has an uncommitted pending write
pending_cnt  out  ADDR_WIDTH+1  number of set scoreboard bits
wr_en  out  1  to reg_file.wr_en
wr_reg  out  ADDR_WIDTH  to reg_file.wr_reg
wr_data  out  DATA_WIDTH  to reg_file.wr_data

Behaviour:
- Reset (async, immediate):
  - wr_en=0, wr_reg=0, wr_data=0.
  - All busy bits=0, pending_cnt=0.
  - last_grant=MEM, so the ALU wins the first tie.
- Handshake:
  - A requester holds valid, rd and data stable until it sees ready=1.
  - Transfer occurs when valid && ready at the posedge.
  - Ready is combinational from the grant logic.
  - Ready is never asserted without the matching valid.
- Arbitration:
  - One valid requester: it is granted.
  - Both valid: the one not in last_grant is granted.
  - last_grant updates only on a transfer.
  - Throughput is 1 write/cycle. There are no bubbles while any valid is high.
- Write port:
  - Registered with 1-cycle latency. Data granted in cycle N appears on wr_en/wr_reg/wr_data in cycle N+1.
  - reg_file commits it at the N+1→N+2 edge.
  - With no transfer in cycle N, wr_en=0 in N+1. wr_reg and wr_data hold their last value.
- x0:
  - A transfer with rd=0 is accepted (ready=1), but wr_en stays 0 next cycle.
  - issue_valid with issue_rd=0 sets no bit.
  - rs1_busy/rs2_busy are always 0 for index 0.
- Scoreboard:
  - busy[i] sets at the posedge with issue_valid && issue_rd==i (i≠0).
  - busy[i] clears at the posedge where wr_en==1 && wr_reg==i, i.e. the edge reg_file actually writes.
  - rsN_busy=busy[rsN], combinational.
  - While the registered write for rsN is on the port (wr_en=1, wr_reg=rsN), rsN_busy stays 1.
- Set and clear on the same register at the same edge: set wins, so the bit stays 1 for the new producer.
- A write to a register whose busy bit is 0 is performed normally and the bit stays 0.
- pending_cnt is a registered count. It changes by +1, -1 or 0 per edge, following the set/clear rules above.
- Reset mid-operation:
  - An in-flight registered write is dropped (wr_en→0 immediately).
  - All reservations are lost.
  - Requesters must re-present their requests after reset.

Test Plan:
1. After reset → wr_en=0, pending_cnt=0, rs1_busy=rs2_busy=0. Then issue x5; next cycle rs1=5 → rs1_busy=1, pending_cnt=1.
2. ALU write x5=0xDEADBEEF with only alu_valid → alu_ready=1 in cycle N; wr_en=1, wr_reg=5, wr_data=0xDEADBEEF in N+1; rs1_busy(5)=1 during N+1 and 0 in N+2; reg_file reads 0xDEADBEEF in N+2.
3. Both valid for 4 cycles (ALU: x1..x4, MEM: x11..x14) → grants ALU, MEM, ALU, MEM; wr_reg sequence 1, 11, 2, 12 on consecutive cycles with no gaps.
4. mem_valid with rd=0, data 0xFFFFFFFF → mem_ready=1, wr_en stays 0; x0 still reads 0. Issue to x0 → pending_cnt unchanged.
5. With x7 busy and its write on the port (wr_en=1, wr_reg=7), assert issue_valid, issue_rd=7 → busy[7] remains 1 and pending_cnt is unchanged.
6. Assert rst asynchronously while wr_en=1 (wr_reg=9) and 3 registers are pending → wr_en=0 before the next edge, pending_cnt=0, and x9 is not written.
